wb_write_queue: RTL and testbench

//  Write-back front end for BANCOREG; drives its endRegDest/dado/sinalEscrita write port.

---
 rtl/wb_write_queue.sv | 126 ++++++++++++
 tb/tb_wb_write_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// Write-back front end: merges ALU results and buffered load results into one registered
// register-file write per cycle. Define WB_FORWARD_EN to add the dadoFwd forwarding port.
module wb_write_queue #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    input  logic [4:0]    alu_dest,
    input  logic [31:0]   alu_dado,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [4:0]    mem_dest,
    input  logic [31:0]   mem_dado,
    output logic [4:0]    endRegDest,
    output logic [31:0]   dado,
    output logic          sinalEscrita,
    input  logic [4:0]    endConsulta,
    output logic          pendente,
`ifdef WB_FORWARD_EN
    output logic [31:0]   dadoFwd,
`endif
    output logic [CW-1:0] ocupacao
);

    localparam int PW = $clog2(DEPTH);

    logic [4:0]       fifo_dest [DEPTH];
    logic [31:0]      fifo_dado [DEPTH];
    logic [DEPTH-1:0] fifo_live;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic alu_issue;
    logic push;
    logic pop;
    logic head_live;

    assign alu_issue = alu_valid && (alu_dest != 5'd0);
    assign mem_ready = (count != CW'(DEPTH));
    // A load to $zero completes its handshake but is dropped here.
    assign push      = mem_valid && mem_ready && (mem_dest != 5'd0);
    assign pop       = !alu_issue && (count != '0);
    assign head_live = fifo_live[rd_ptr];
    assign ocupacao  = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            fifo_live    <= '0;
            endRegDest   <= '0;
            dado         <= '0;
            sinalEscrita <= 1'b0;
        end else begin
            // Kill runs before the push so an entry enqueued on this same edge survives.
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_issue && fifo_live[i] && (fifo_dest[i] == alu_dest))
                    fifo_live[i] <= 1'b0;
            end
            if (pop) begin
                fifo_live[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + PW'(1);
            end
            if (push) begin
                fifo_live[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (alu_issue) begin
                endRegDest   <= alu_dest;
                dado         <= alu_dado;
                sinalEscrita <= 1'b1;
            end else if (pop && head_live) begin
                endRegDest   <= fifo_dest[rd_ptr];
                dado         <= fifo_dado[rd_ptr];
                sinalEscrita <= 1'b1;
            end else begin
                sinalEscrita <= 1'b0;
            end
        end
    end

    // NOTE: payload storage has no reset; the live bits alone say which slots mean anything.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dest[wr_ptr] <= mem_dest;
            fifo_dado[wr_ptr] <= mem_dado;
        end
    end

    always_comb begin
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_live[i] && (fifo_dest[i] == endConsulta))
                hit = 1'b1;
        end
        pendente = (endConsulta != 5'd0) &&
                   (hit || (sinalEscrita && (endRegDest == endConsulta)));
    end

`ifdef WB_FORWARD_EN
    // Walk head to tail so the youngest matching live entry wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = rd_ptr;
        dadoFwd = (sinalEscrita && (endConsulta != 5'd0) && (endRegDest == endConsulta))
                  ? dado : 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (fifo_live[idx] && (fifo_dest[idx] == endConsulta))
                dadoFwd = fifo_dado[idx];
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: a queue-based model predicts each write, which is
// compared when the DUT raises sinalEscrita. Checks dadoFwd when WB_FORWARD_EN is defined.
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid;
    logic [4:0]    alu_dest;
    logic [31:0]   alu_dado;
    logic          mem_valid;
    logic          mem_ready;
    logic [4:0]    mem_dest;
    logic [31:0]   mem_dado;
    logic [4:0]    endRegDest;
    logic [31:0]   dado;
    logic          sinalEscrita;
    logic [4:0]    endConsulta;
    logic          pendente;
    logic [CW-1:0] ocupacao;
`ifdef WB_FORWARD_EN
    logic [31:0]   dadoFwd;
`endif

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_dest     (alu_dest),
        .alu_dado     (alu_dado),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_dest     (mem_dest),
        .mem_dado     (mem_dado),
        .endRegDest   (endRegDest),
        .dado         (dado),
        .sinalEscrita (sinalEscrita),
        .endConsulta  (endConsulta),
        .pendente     (pendente),
`ifdef WB_FORWARD_EN
        .dadoFwd      (dadoFwd),
`endif
        .ocupacao     (ocupacao)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        bit          live;
    } entry_t;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } wr_t;

    entry_t      m_fifo[$];
    wr_t         exp_q[$];
    bit          exp_we;
    logic [4:0]  m_last_dest;
    logic [31:0] m_last_data;
    logic [31:0] bank [32];
    int          checks;
    int          errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_pend(input logic [4:0] q);
        bit hit;
        hit = exp_we && (m_last_dest == q);
        foreach (m_fifo[i])
            if (m_fifo[i].live && m_fifo[i].dest == q) hit = 1'b1;
        return (q != 5'd0) && hit;
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] q);
        logic [31:0] r;
        r = (exp_we && q != 5'd0 && m_last_dest == q) ? m_last_data : 32'd0;
        foreach (m_fifo[i])
            if (m_fifo[i].live && m_fifo[i].dest == q) r = m_fifo[i].data;
        return r;
    endfunction

    // One clock: drive just after a negedge, predict, then compare at the next negedge.
    task automatic cycle(input bit av, input logic [4:0] ad, input logic [31:0] ax,
                         input bit mv, input logic [4:0] md, input logic [31:0] mx);
        bit     accept;
        entry_t e;
        wr_t    w;
        alu_valid = av; alu_dest = ad; alu_dado = ax;
        mem_valid = mv; mem_dest = md; mem_dado = mx;
        #1;
        check("ocupacao", 32'(ocupacao), 32'(m_fifo.size()));
        check("mem_ready", 32'(mem_ready), 32'(m_fifo.size() != DEPTH));
        accept = mv && (m_fifo.size() != DEPTH);
        exp_we = 1'b0;
        if (av && ad != 5'd0) begin
            exp_q.push_back('{dest: ad, data: ax});
            exp_we = 1'b1; m_last_dest = ad; m_last_data = ax;
            foreach (m_fifo[i])
                if (m_fifo[i].live && m_fifo[i].dest == ad) m_fifo[i].live = 1'b0;
        end else if (m_fifo.size() > 0) begin
            e = m_fifo.pop_front();
            if (e.live) begin
                exp_q.push_back('{dest: e.dest, data: e.data});
                exp_we = 1'b1; m_last_dest = e.dest; m_last_data = e.data;
            end
        end
        if (accept && md != 5'd0) m_fifo.push_back('{dest: md, data: mx, live: 1'b1});
        @(negedge clk);
        check("sinalEscrita", 32'(sinalEscrita), 32'(exp_we));
        if (sinalEscrita) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", 32'd1, 32'd0);
            end else begin
                w = exp_q.pop_front();
                check("endRegDest", 32'(endRegDest), 32'(w.dest));
                check("dado", dado, w.data);
            end
            bank[endRegDest] = dado;
        end else begin
            check("hold_dest", 32'(endRegDest), 32'(m_last_dest));
            check("hold_dado", dado, m_last_data);
        end
        check("pendente", 32'(pendente), 32'(model_pend(endConsulta)));
`ifdef WB_FORWARD_EN
        check("dadoFwd", dadoFwd, model_fwd(endConsulta));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0;
        exp_we = 1'b0; m_last_dest = '0; m_last_data = '0;
        foreach (bank[i]) bank[i] = '0;
        reset = 1'b0; endConsulta = 5'd5;
        alu_valid = 0; alu_dest = '0; alu_dado = '0;
        mem_valid = 0; mem_dest = '0; mem_dado = '0;
        @(negedge clk); @(negedge clk);
        check("rst_dest", 32'(endRegDest), 32'd0);
        check("rst_dado", dado, 32'd0);
        check("rst_we", 32'(sinalEscrita), 32'd0);
        check("rst_occ", 32'(ocupacao), 32'd0);
        check("rst_pend", 32'(pendente), 32'd0);
        reset = 1'b1;
        #1 check("rst_ready", 32'(mem_ready), 32'd1);

        // ALU only, then read back through the register-file image.
        cycle(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        check("bank5", bank[5], 32'hDEADBEEF);
        idle(2);

        // Backpressure: ALU busy every cycle while loads fill the FIFO.
        endConsulta = 5'd12;
        for (int i = 0; i < 5; i++)
            cycle(1, 5'd7, 32'h100 + 32'(i), 1, 5'(10 + i), 32'h1000 + 32'(i));
        check("full_occ", 32'(ocupacao), 32'(DEPTH));
        check("full_ready", 32'(mem_ready), 32'd0);
        cycle(0, 5'd0, 32'd0, 1, 5'd15, 32'h1555);
        cycle(0, 5'd0, 32'd0, 1, 5'd16, 32'h1666);
        cycle(0, 5'd0, 32'd0, 1, 5'd17, 32'h1777);
        idle(6);
        check("drain_occ", 32'(ocupacao), 32'd0);

        // Kill: a younger ALU write to the same register replaces the queued load.
        endConsulta = 5'd9;
        cycle(1, 5'd7, 32'h1, 1, 5'd9, 32'h11);
        cycle(1, 5'd9, 32'h22, 0, 5'd0, 32'd0);
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        check("kill_pend", 32'(pendente), 32'd0);
        check("bank9", bank[9], 32'h22);
        // Same-edge: the load accepted with the ALU issue is younger and survives.
        cycle(1, 5'd9, 32'h33, 1, 5'd9, 32'h44);
        idle(2);
        check("bank9_same_edge", bank[9], 32'h44);

        // $zero on both paths never writes and never enqueues.
        endConsulta = 5'd0;
        for (int i = 0; i < 3; i++) cycle(1, 5'd0, 32'hBAD, 1, 5'd0, 32'hBAD0);
        check("zero_occ", 32'(ocupacao), 32'd0);

        // Two queued loads to the same register: the younger one is forwarded.
        endConsulta = 5'd3;
        cycle(1, 5'd7, 32'h2, 1, 5'd3, 32'hA);
        cycle(1, 5'd7, 32'h3, 1, 5'd3, 32'hB);
        check("pend3", 32'(pendente), 32'd1);
        idle(3);

        // Random traffic with a small register set so kills and matches are common.
        for (int i = 0; i < 300; i++) begin
            endConsulta = 5'($urandom_range(0, 7));
            cycle(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
        end
        idle(6);

        // Asynchronous reset mid-burst with three loads queued.
        endConsulta = 5'd20;
        for (int i = 0; i < 3; i++)
            cycle(1, 5'd7, 32'h200 + 32'(i), 1, 5'(20 + i), 32'h2000 + 32'(i));
        #2 reset = 1'b0;
        #1;
        check("mid_rst_dest", 32'(endRegDest), 32'd0);
        check("mid_rst_dado", dado, 32'd0);
        check("mid_rst_we", 32'(sinalEscrita), 32'd0);
        check("mid_rst_occ", 32'(ocupacao), 32'd0);
        check("mid_rst_pend", 32'(pendente), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_fifo.delete(); exp_q.delete();
        exp_we = 1'b0; m_last_dest = '0; m_last_data = '0;
        #1;
        check("post_rst_occ", 32'(ocupacao), 32'd0);
        check("post_rst_ready", 32'(mem_ready), 32'd1);
        idle(2);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
